// File: rtl/control_unit_legv8.sv
// Single-cycle LEGv8 instruction decoder: builds the 40-bit control word
// and the 64-bit constant, both held at zero until the first clock after reset.
module control_unit_legv8 (
    output logic [39:0] ControlWord,
    output logic [63:0] constant,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    input  logic        reset,
    input  logic        clock
);
    localparam logic [4:0] FS_AND  = 5'b00000;
    localparam logic [4:0] FS_ORR  = 5'b00001;
    localparam logic [4:0] FS_EOR  = 5'b00010;
    localparam logic [4:0] FS_ADD  = 5'b00100;
    localparam logic [4:0] FS_SUB  = 5'b00101;
    localparam logic [4:0] FS_LSL  = 5'b01000;
    localparam logic [4:0] FS_LSR  = 5'b01001;
    localparam logic [4:0] FS_PASA = 5'b01100;
    localparam logic [4:0] FS_PASB = 5'b01101;
    localparam logic [4:0] FS_MOVK = 5'b01110;

    logic        run;
    logic        rw, mw, mr, bs, sl;
    logic [4:0]  fs, sa, sb, da;
    logic [1:0]  ds, pc, hw;
    logic [63:0] k;
    logic        matched, fmt_r, fmt_i, fmt_sh, fmt_d, fmt_iw;
    logic        base, cond_ok;
    logic        v, c, n, z, zl;

    assign {v, c, n, z, zl} = status;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) run <= 1'b0;
        else       run <= 1'b1;
    end

    // Odd condition codes invert their even partner, except 1111 (always).
    always_comb begin
        case (instruction[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        cond_ok = (instruction[3:1] == 3'd7) ? 1'b1 : base ^ instruction[0];
    end

    always_comb begin
        rw = 1'b0; mw = 1'b0; mr = 1'b0; bs = 1'b0; sl = 1'b0;
        fs = 5'd0; sa = 5'd0; sb = 5'd0; da = 5'd0;
        ds = 2'd0; pc = 2'd1; hw = 2'd0; k = 64'd0;
        fmt_r = 1'b0; fmt_i = 1'b0; fmt_sh = 1'b0; fmt_d = 1'b0; fmt_iw = 1'b0;
        matched = 1'b1;
        case (instruction[31:21])
            11'b10001011000: begin fmt_r = 1'b1; fs = FS_ADD; end
            11'b11001011000: begin fmt_r = 1'b1; fs = FS_SUB; end
            11'b10001010000: begin fmt_r = 1'b1; fs = FS_AND; end
            11'b10101010000: begin fmt_r = 1'b1; fs = FS_ORR; end
            11'b11001010000: begin fmt_r = 1'b1; fs = FS_EOR; end
            11'b10101011000: begin fmt_r = 1'b1; fs = FS_ADD; sl = 1'b1; end
            11'b11101011000: begin fmt_r = 1'b1; fs = FS_SUB; sl = 1'b1; end
            11'b11101010000: begin fmt_r = 1'b1; fs = FS_AND; sl = 1'b1; end
            11'b11010011010: begin fmt_sh = 1'b1; fs = FS_LSR; end
            11'b11010011011: begin fmt_sh = 1'b1; fs = FS_LSL; end
            11'b11111000000: begin
                fmt_d = 1'b1; sb = instruction[4:0]; mw = 1'b1;
            end
            11'b11111000010: begin
                fmt_d = 1'b1; da = instruction[4:0];
                mr = 1'b1; ds = 2'd1; rw = 1'b1;
            end
            11'b11010110000: begin sa = instruction[9:5]; pc = 2'd3; end
            default: matched = 1'b0;
        endcase
        if (!matched) begin
            matched = 1'b1;
            case (instruction[31:22])
                10'b1001000100: begin fmt_i = 1'b1; fs = FS_ADD; end
                10'b1101000100: begin fmt_i = 1'b1; fs = FS_SUB; end
                10'b1001001000: begin fmt_i = 1'b1; fs = FS_AND; end
                10'b1011001000: begin fmt_i = 1'b1; fs = FS_ORR; end
                10'b1101001000: begin fmt_i = 1'b1; fs = FS_EOR; end
                10'b1011000100: begin fmt_i = 1'b1; fs = FS_ADD; sl = 1'b1; end
                10'b1111000100: begin fmt_i = 1'b1; fs = FS_SUB; sl = 1'b1; end
                10'b1111001000: begin fmt_i = 1'b1; fs = FS_AND; sl = 1'b1; end
                default: matched = 1'b0;
            endcase
        end
        if (!matched) begin
            matched = 1'b1;
            case (instruction[31:23])
                9'b110100101: begin fmt_iw = 1'b1; fs = FS_PASB; end
                9'b111100101: begin
                    fmt_iw = 1'b1; fs = FS_MOVK; sa = instruction[4:0];
                end
                default: matched = 1'b0;
            endcase
        end
        if (!matched) begin
            matched = 1'b1;
            case (instruction[31:24])
                8'b10110100: begin
                    sa = instruction[4:0]; fs = FS_PASA;
                    pc = zl ? 2'd2 : 2'd1;
                end
                8'b10110101: begin
                    sa = instruction[4:0]; fs = FS_PASA;
                    pc = zl ? 2'd1 : 2'd2;
                end
                8'b01010100: pc = cond_ok ? 2'd2 : 2'd1;
                default: matched = 1'b0;
            endcase
            if (matched)
                k = {{43{instruction[23]}}, instruction[23:5], 2'b00};
        end
        if (!matched) begin
            case (instruction[31:26])
                6'b000101: begin
                    pc = 2'd2;
                    k = {{36{instruction[25]}}, instruction[25:0], 2'b00};
                end
                6'b100101: begin
                    pc = 2'd2; da = 5'd30; ds = 2'd2; rw = 1'b1;
                    k = {{36{instruction[25]}}, instruction[25:0], 2'b00};
                end
                default: ;
            endcase
        end
        if (fmt_r) begin
            sa = instruction[9:5]; sb = instruction[20:16];
            da = instruction[4:0]; rw = 1'b1;
        end
        if (fmt_sh) begin
            sa = instruction[9:5]; da = instruction[4:0];
            bs = 1'b1; rw = 1'b1; k = {58'd0, instruction[15:10]};
        end
        if (fmt_i) begin
            sa = instruction[9:5]; da = instruction[4:0];
            bs = 1'b1; rw = 1'b1; k = {52'd0, instruction[21:10]};
        end
        if (fmt_d) begin
            sa = instruction[9:5]; fs = FS_ADD; bs = 1'b1;
            k = {{55{instruction[20]}}, instruction[20:12]};
        end
        if (fmt_iw) begin
            da = instruction[4:0]; hw = instruction[22:21];
            bs = 1'b1; rw = 1'b1;
            k = {48'd0, instruction[20:5]} << {instruction[22:21], 4'b0000};
        end
    end

    // Output gating is combinational on reset so a mid-cycle reset bites at once.
    always_comb begin
        if (reset || !run) begin
            ControlWord = 40'd0;
            constant    = 64'd0;
        end else begin
            ControlWord = {9'd0, hw, pc, ds, da, sb, sa, fs, sl, bs, mr, mw, rw};
            constant    = k;
        end
    end
endmodule

// File: tb/tb_control_unit_legv8.sv
// Randomised bench for control_unit_legv8 against a table-driven
// instruction model, plus directed reset and boundary vectors.
module tb_control_unit_legv8;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  status;
    logic [39:0] ControlWord;
    logic [63:0] constant;

    int vectors = 0;
    int miscompares = 0;

    control_unit_legv8 dut (
        .ControlWord(ControlWord),
        .constant(constant),
        .instruction(instruction),
        .status(status),
        .reset(reset),
        .clock(clock)
    );

    always #5 clock = ~clock;

    // ADD SUB AND ORR EOR ADDS SUBS ANDS LSR LSL STUR LDUR BR
    // ADDI SUBI ANDI ORRI EORI ADDIS SUBIS ANDIS MOVZ MOVK
    // CBZ CBNZ B.cond B BL
    localparam int NOPS = 28;
    localparam int unsigned OPC [NOPS] = '{
        'b10001011000, 'b11001011000, 'b10001010000, 'b10101010000,
        'b11001010000, 'b10101011000, 'b11101011000, 'b11101010000,
        'b11010011010, 'b11010011011, 'b11111000000, 'b11111000010,
        'b11010110000,
        'b1001000100, 'b1101000100, 'b1001001000, 'b1011001000,
        'b1101001000, 'b1011000100, 'b1111000100, 'b1111001000,
        'b110100101, 'b111100101,
        'b10110100, 'b10110101, 'b01010100,
        'b000101, 'b100101};
    localparam int WID [NOPS] = '{
        11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11, 11,
        10, 10, 10, 10, 10, 10, 10, 10,
        9, 9, 8, 8, 8, 6, 6};
    localparam int FSV [NOPS] = '{
        4, 5, 0, 1, 2, 4, 5, 0, 9, 8, 4, 4, 0,
        4, 5, 0, 1, 2, 4, 5, 0,
        13, 14, 12, 12, 0, 0, 0};

    function automatic bit cond_true(input int cd, input bit fv, input bit fc,
                                     input bit fn, input bit fz);
        bit gt;
        gt = !fz && (fn == fv);
        case (cd)
            0:  return fz;
            1:  return !fz;
            2:  return fc;
            3:  return !fc;
            4:  return fn;
            5:  return !fn;
            6:  return fv;
            7:  return !fv;
            8:  return fc && !fz;
            9:  return !(fc && !fz);
            10: return fn == fv;
            11: return fn != fv;
            12: return gt;
            13: return !gt;
            default: return 1'b1;
        endcase
    endfunction

    function automatic void model(input logic [31:0] i, input logic [4:0] st,
                                  output logic [39:0] cw, output logic [63:0] k);
        int idx, rw, mw, mr, bs, sl, fs, sa, sb, da, ds, pc, hw;
        longint sv;
        bit taken;
        idx = -1;
        for (int t = 0; t < NOPS; t++)
            if (idx < 0 && (i >> (32 - WID[t])) == OPC[t]) idx = t;
        rw = 0; mw = 0; mr = 0; bs = 0; sl = 0; fs = 0;
        sa = 0; sb = 0; da = 0; ds = 0; pc = 1; hw = 0; k = 0;
        if (idx >= 0) fs = FSV[idx];
        if (idx == 5 || idx == 6 || idx == 7 || idx == 18 || idx == 19 || idx == 20)
            sl = 1;
        if (idx >= 0 && idx <= 7) begin
            sa = i[9:5]; sb = i[20:16]; da = i[4:0]; rw = 1;
        end else if (idx == 8 || idx == 9) begin
            sa = i[9:5]; da = i[4:0]; bs = 1; rw = 1; k = 64'(i[15:10]);
        end else if (idx == 10 || idx == 11) begin
            sa = i[9:5]; bs = 1;
            sv = longint'(i[20:12]);
            if (sv >= 256) sv -= 512;
            k = 64'(sv);
            if (idx == 10) begin sb = i[4:0]; mw = 1; end
            else begin da = i[4:0]; mr = 1; ds = 1; rw = 1; end
        end else if (idx == 12) begin
            sa = i[9:5]; pc = 3;
        end else if (idx >= 13 && idx <= 20) begin
            sa = i[9:5]; da = i[4:0]; bs = 1; rw = 1; k = 64'(i[21:10]);
        end else if (idx == 21 || idx == 22) begin
            da = i[4:0]; hw = i[22:21]; bs = 1; rw = 1;
            k = 64'(i[20:5]) * (64'd1 << (16 * hw));
            if (idx == 22) sa = i[4:0];
        end else if (idx >= 23 && idx <= 25) begin
            sv = longint'(i[23:5]);
            if (sv >= (1 << 18)) sv -= (1 << 19);
            k = 64'(sv * 4);
            if (idx == 25) taken = cond_true(int'(i[3:0]), st[4], st[3], st[2], st[1]);
            else begin
                sa = i[4:0];
                taken = (idx == 23) ? st[0] : !st[0];
            end
            pc = taken ? 2 : 1;
        end else if (idx == 26 || idx == 27) begin
            sv = longint'(i[25:0]);
            if (sv >= (1 << 25)) sv -= (1 << 26);
            k = 64'(sv * 4);
            pc = 2;
            if (idx == 27) begin da = 30; ds = 2; rw = 1; end
        end
        cw = 40'(rw + mw * 2 + mr * 4 + bs * 8 + sl * 16 + fs * 32 +
                 longint'(sa) * 1024 + longint'(sb) * (1 << 15) +
                 longint'(da) * (1 << 20) + longint'(ds) * (1 << 25) +
                 longint'(pc) * (1 << 27) + longint'(hw) * (1 << 29));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply(input string tag, input logic [31:0] i, input logic [4:0] st);
        logic [39:0] ecw;
        logic [63:0] ek;
        instruction = i;
        status = st;
        #1;
        model(i, st, ecw, ek);
        check({tag, ".cw"}, 64'(ControlWord), 64'(ecw));
        check({tag, ".k"}, constant, ek);
    endtask

    localparam logic [31:0] I_ADD = {11'b10001011000, 5'd31, 6'd0, 5'd2, 5'd0};

    initial begin
        logic [31:0] ri;
        int idx;
        reset = 1'b1;
        instruction = I_ADD;
        status = 5'd0;
        #3;
        check("rst_cw", 64'(ControlWord), 64'd0);
        check("rst_k", constant, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("prerun_cw", 64'(ControlWord), 64'd0);
        @(posedge clock);
        #1;
        check("add_cw", 64'(ControlWord), 64'h00080F8881);
        check("add_k", constant, 64'd0);

        apply("subs", {11'b11101011000, 5'd5, 6'd0, 5'd4, 5'd3}, 5'd0);
        check("subs_lit", 64'(ControlWord), 64'h00083290B1);
        apply("ldur", {11'b11111000010, 9'h1FF, 2'b00, 5'd1, 5'd2}, 5'd0);
        check("ldur_k", constant, 64'hFFFFFFFFFFFFFFFF);
        check("ldur_ds", 64'(ControlWord[26:25]), 64'd1);
        check("ldur_mr", 64'(ControlWord[2]), 64'd1);
        apply("cbz0", {8'b10110100, 19'h7FFFF, 5'd3}, 5'b00000);
        check("cbz0_pc", 64'(ControlWord[28:27]), 64'd1);
        check("cbz0_k", constant, 64'hFFFFFFFFFFFFFFFC);
        apply("cbz1", {8'b10110100, 19'h7FFFF, 5'd3}, 5'b00001);
        check("cbz1_pc", 64'(ControlWord[28:27]), 64'd2);
        check("cbz1_k", constant, 64'hFFFFFFFFFFFFFFFC);
        apply("beq_t", {8'b01010100, 19'd10, 5'b00000}, 5'b00010);
        check("beq_t_pc", 64'(ControlWord[28:27]), 64'd2);
        apply("beq_n", {8'b01010100, 19'd10, 5'b00000}, 5'b00000);
        check("beq_n_pc", 64'(ControlWord[28:27]), 64'd1);
        apply("bgt", {8'b01010100, 19'd10, 5'b01100}, 5'b10100);
        check("bgt_pc", 64'(ControlWord[28:27]), 64'd2);
        apply("movz", {9'b110100101, 2'd2, 16'h1234, 5'd7}, 5'd0);
        check("movz_k", constant, 64'h0000123400000000);
        check("movz_hw", 64'(ControlWord[30:29]), 64'd2);
        check("movz_fs", 64'(ControlWord[9:5]), 64'd13);
        apply("bl", {6'b100101, 26'd100}, 5'd0);
        check("bl_da", 64'(ControlWord[24:20]), 64'd30);
        check("bl_ds", 64'(ControlWord[26:25]), 64'd2);
        check("bl_rw", 64'(ControlWord[0]), 64'd1);
        check("bl_pc", 64'(ControlWord[28:27]), 64'd2);
        apply("nop", 32'h00000000, 5'd0);
        check("nop_cw", 64'(ControlWord), 64'h0008000000);

        for (int n = 0; n < 600; n++) begin
            @(negedge clock);
            if ($urandom_range(0, 4) == 0) ri = $urandom;
            else begin
                idx = $urandom_range(0, NOPS - 1);
                ri = (OPC[idx] << (32 - WID[idx])) |
                     ($urandom & ((32'h1 << (32 - WID[idx])) - 32'h1));
            end
            apply("rand", ri, 5'($urandom));
        end

        @(negedge clock);
        instruction = I_ADD;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_cw", 64'(ControlWord), 64'd0);
        check("midrst_k", constant, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rerun_cw", 64'(ControlWord), 64'd0);
        @(posedge clock);
        #1;
        check("resume_cw", 64'(ControlWord), 64'h00080F8881);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
